// File: rtl/baud_gen_tx.sv
// Transmit baud clock generator: divides clk to a 50%-duty square wave at one of four rates.
// Latency: select is registered; a rate change restarts the divider on the next edge, first rise HALF_new cycles later.
// Backpressure: none; free-running output with no handshake.
module baud_gen_tx #(
   parameter int CLK_FREQ = 50_000_000,
   parameter int BAUD0    = 2400,
   parameter int BAUD1    = 4800,
   parameter int BAUD2    = 9600,
   parameter int BAUD3    = 19200,
   parameter int CNT_W    = 16
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic [1:0] baud_rate,
   output logic       baud_clk
);

   // Half-period divisors, rounded to nearest at elaboration.
   localparam int HALF0 = (CLK_FREQ + BAUD0) / (2 * BAUD0);
   localparam int HALF1 = (CLK_FREQ + BAUD1) / (2 * BAUD1);
   localparam int HALF2 = (CLK_FREQ + BAUD2) / (2 * BAUD2);
   localparam int HALF3 = (CLK_FREQ + BAUD3) / (2 * BAUD3);
   localparam int CNT_MAX = (2 ** CNT_W) - 1;

   // A divisor of zero or one that overflows the counter cannot produce a valid wave.
   if (HALF0 < 1 || HALF0 > CNT_MAX) begin : g_bad_half0
      $error("baud_gen_tx: HALF0 out of range for CNT_W");
   end
   if (HALF1 < 1 || HALF1 > CNT_MAX) begin : g_bad_half1
      $error("baud_gen_tx: HALF1 out of range for CNT_W");
   end
   if (HALF2 < 1 || HALF2 > CNT_MAX) begin : g_bad_half2
      $error("baud_gen_tx: HALF2 out of range for CNT_W");
   end
   if (HALF3 < 1 || HALF3 > CNT_MAX) begin : g_bad_half3
      $error("baud_gen_tx: HALF3 out of range for CNT_W");
   end

   // Terminal counts (HALF-1) in counter width.
   localparam logic [CNT_W-1:0] TERM0 = CNT_W'(HALF0 - 1);
   localparam logic [CNT_W-1:0] TERM1 = CNT_W'(HALF1 - 1);
   localparam logic [CNT_W-1:0] TERM2 = CNT_W'(HALF2 - 1);
   localparam logic [CNT_W-1:0] TERM3 = CNT_W'(HALF3 - 1);

   logic [1:0]       baud_rate_q;
   logic [CNT_W-1:0] counter;
   logic [CNT_W-1:0] term_sel;

   // Terminal count follows the registered select so a changing input never shortens a half period.
   always_comb begin
      term_sel = TERM0;
      case (baud_rate_q)
         2'b00:   term_sel = TERM0;
         2'b01:   term_sel = TERM1;
         2'b10:   term_sel = TERM2;
         2'b11:   term_sel = TERM3;
         default: term_sel = TERM0;
      endcase
   end

   // Divider: reset beats rate change, rate change restarts from a clean low phase, else count and toggle.
   always_ff @(posedge clk) begin
      baud_rate_q <= baud_rate;
      if (!rst_n) begin
         counter  <= '0;
         baud_clk <= 1'b0;
      end else if (baud_rate != baud_rate_q) begin
         counter  <= '0;
         baud_clk <= 1'b0;
      end else if (counter >= term_sel) begin
         // >= rather than == so a corrupted count above terminal wraps instead of running away.
         counter  <= '0;
         baud_clk <= ~baud_clk;
      end else begin
         counter  <= counter + 1'b1;
      end
   end

endmodule

// File: tb/tb_baud_gen_tx.sv
// Bench for baud_gen_tx: a scaled instance exercises every rate and restart case,
// a default-parameter instance confirms the real 50 MHz / 2400 baud timing.
// Expected edge gaps are queued when stimulus is applied and compared as edges arrive.
module tb_baud_gen_tx;

   logic       clk;
   logic       rst_n;
   logic [1:0] rate;
   logic       bclk;
   logic [1:0] rate_def;
   logic       bclk_def;

   int cyc;
   int vecs;
   int errs;

   // Scaled instance: CLK_FREQ 12000 gives halves 25, 13, 6, 3 for bauds 240/480/960/1920.
   int h_tab[4] = '{25, 13, 6, 3};

   typedef struct {
      bit rise;
      int gap;
   } exp_t;

   exp_t exp_q[$];

   baud_gen_tx #(
      .CLK_FREQ(12000),
      .BAUD0   (240),
      .BAUD1   (480),
      .BAUD2   (960),
      .BAUD3   (1920),
      .CNT_W   (8)
   ) dut (
      .clk      (clk),
      .rst_n    (rst_n),
      .baud_rate(rate),
      .baud_clk (bclk)
   );

   baud_gen_tx dut_def (
      .clk      (clk),
      .rst_n    (rst_n),
      .baud_rate(rate_def),
      .baud_clk (bclk_def)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Cycle index: number of rising edges so far; read on falling edges.
   always @(posedge clk) cyc <= cyc + 1;

   // Waits (bounded) for the next transition of the chosen output to level 'want'; at = -1 on timeout.
   task automatic wait_edge(input bit def, input bit want, input int budget, output int at);
      logic prev;
      logic cur;
      at   = -1;
      prev = def ? bclk_def : bclk;
      for (int n = 0; n < budget; n++) begin
         @(negedge clk);
         cur = def ? bclk_def : bclk;
         if (cur === want && prev !== want) begin
            at = cyc;
            return;
         end
         prev = cur;
      end
   endtask

   // Queue 'n' alternating half periods of length h, starting with a rising edge.
   task automatic push_halves(input int h, input int n);
      exp_t e;
      for (int i = 0; i < n; i++) begin
         e.rise = (i % 2 == 0);
         e.gap  = h;
         exp_q.push_back(e);
      end
   endtask

   int t_rst;

   task automatic test_reset();
      rst_n    = 1'b0;
      rate     = 2'b00;
      rate_def = 2'b00;
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         vecs++;
         if (bclk !== 1'b0 || bclk_def !== 1'b0 || dut.counter !== 8'd0) begin
            errs++;
            $display("FAIL reset[%0d]: baud_clk=%b def_baud_clk=%b counter=%0d, want 0/0/0",
                     i, bclk, bclk_def, dut.counter);
         end
      end
      t_rst = cyc;
      rst_n = 1'b1;
   endtask

   task automatic test_first_edge();
      int   at;
      int   last;
      exp_t e;
      last = t_rst;
      push_halves(h_tab[0], 8);
      while (exp_q.size() > 0) begin
         e = exp_q.pop_front();
         wait_edge(1'b0, e.rise, 2 * e.gap + 8, at);
         vecs++;
         if (at < 0 || at - last != e.gap) begin
            errs++;
            $display("FAIL first_edge rate00 %s: gap %0d, want %0d",
                     e.rise ? "rise" : "fall", (at < 0) ? -1 : at - last, e.gap);
         end
         if (at >= 0) last = at;
      end
   endtask

   task automatic test_default_rate();
      int   at;
      int   last;
      int   first_rise;
      int   n;
      exp_t e;
      last       = t_rst;
      first_rise = -1;
      n          = 0;
      push_halves(10417, 3);
      while (exp_q.size() > 0) begin
         e = exp_q.pop_front();
         wait_edge(1'b1, e.rise, 2 * e.gap + 8, at);
         vecs++;
         if (at < 0 || at - last != e.gap) begin
            errs++;
            $display("FAIL default_rate edge%0d: gap %0d, want %0d", n, (at < 0) ? -1 : at - last, e.gap);
         end
         if (n == 0) first_rise = at;
         if (at >= 0) last = at;
         n++;
      end
      vecs++;
      if (first_rise < 0 || last - first_rise != 20834) begin
         errs++;
         $display("FAIL default_period: %0d cycles, want 20834", last - first_rise);
      end
   endtask

   task automatic test_rates();
      int   at;
      int   last;
      exp_t e;
      for (int r = 1; r < 4; r++) begin
         rate = r[1:0];
         @(negedge clk);
         vecs++;
         if (bclk !== 1'b0) begin
            errs++;
            $display("FAIL rate%0d restart: baud_clk=%b, want 0", r, bclk);
         end
         last = cyc;
         push_halves(h_tab[r], 8);
         while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            wait_edge(1'b0, e.rise, 2 * e.gap + 8, at);
            vecs++;
            if (at < 0 || at - last != e.gap) begin
               errs++;
               $display("FAIL rate%0d %s: gap %0d, want %0d", r, e.rise ? "rise" : "fall",
                        (at < 0) ? -1 : at - last, e.gap);
            end
            if (at >= 0) last = at;
         end
      end
   endtask

   task automatic test_mid_change();
      int   at;
      int   last;
      exp_t e;
      rate = 2'b00;
      wait_edge(1'b0, 1'b1, 2 * h_tab[0] + 8, at);
      repeat (12) @(negedge clk);
      vecs++;
      if (bclk !== 1'b1) begin
         errs++;
         $display("FAIL mid_change setup: baud_clk=%b, want 1 mid high phase", bclk);
      end
      rate = 2'b11;
      @(negedge clk);
      vecs++;
      if (bclk !== 1'b0 || dut.counter !== 8'd0) begin
         errs++;
         $display("FAIL mid_change restart: baud_clk=%b counter=%0d, want 0/0", bclk, dut.counter);
      end
      last = cyc;
      push_halves(h_tab[3], 5);
      while (exp_q.size() > 0) begin
         e = exp_q.pop_front();
         wait_edge(1'b0, e.rise, 2 * e.gap + 8, at);
         vecs++;
         if (at < 0 || at - last != e.gap) begin
            errs++;
            $display("FAIL mid_change %s: gap %0d, want %0d", e.rise ? "rise" : "fall",
                     (at < 0) ? -1 : at - last, e.gap);
         end
         if (at >= 0) last = at;
      end
   endtask

   task automatic test_mid_reset();
      int   at;
      int   last;
      exp_t e;
      rate = 2'b10;
      wait_edge(1'b0, 1'b1, 4 * h_tab[2] + 8, at);
      repeat (2) @(negedge clk);
      rst_n = 1'b0;
      @(negedge clk);
      vecs++;
      if (bclk !== 1'b0 || dut.counter !== 8'd0) begin
         errs++;
         $display("FAIL mid_reset: baud_clk=%b counter=%0d, want 0/0", bclk, dut.counter);
      end
      rst_n = 1'b1;
      last  = cyc;
      push_halves(h_tab[2], 3);
      while (exp_q.size() > 0) begin
         e = exp_q.pop_front();
         wait_edge(1'b0, e.rise, 2 * e.gap + 8, at);
         vecs++;
         if (at < 0 || at - last != e.gap) begin
            errs++;
            $display("FAIL mid_reset %s: gap %0d, want %0d", e.rise ? "rise" : "fall",
                     (at < 0) ? -1 : at - last, e.gap);
         end
         if (at >= 0) last = at;
      end
   endtask

   task automatic test_back_to_back();
      int   last;
      int   n;
      int   budget;
      logic prev;
      exp_t e;
      // Currently at rate 10 just after a rising edge; rewrite the same code every cycle.
      last   = cyc;
      prev   = bclk;
      n      = 0;
      budget = 10 * h_tab[2] + 8;
      push_halves(h_tab[2], 8);
      exp_q.pop_front();
      while (exp_q.size() > 0 && budget > 0) begin
         rate = 2'b10;
         @(negedge clk);
         budget--;
         if (bclk !== prev) begin
            e = exp_q.pop_front();
            vecs++;
            if (bclk !== e.rise || cyc - last != e.gap) begin
               errs++;
               $display("FAIL back_to_back edge%0d: level %b gap %0d, want %b gap %0d",
                        n, bclk, cyc - last, e.rise, e.gap);
            end
            last = cyc;
            n++;
         end
         prev = bclk;
      end
      if (exp_q.size() > 0) begin
         vecs++;
         errs++;
         $display("FAIL back_to_back timeout: %0d edges missing, want 0", exp_q.size());
         exp_q.delete();
      end
   endtask

   initial begin
      cyc  = 0;
      vecs = 0;
      errs = 0;
      test_reset();
      test_first_edge();
      test_default_rate();
      test_rates();
      test_mid_change();
      test_mid_reset();
      test_back_to_back();
      $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
      $finish;
   end

endmodule

// File: doc/baud_gen_tx.md
Name: baud_gen_tx

Overview:
- Transmit-side baud clock generator for the UART.
- Divides the system clock (50 MHz nominal) down to a 50%-duty square wave at one of four selectable baud rates.
- Output baud_clk drives the UART transmitter's bit timing. Rate is selected at run time by a 2-bit code.

Parameters:
- CLK_FREQ, 50_000_000, system clock frequency in Hz.
- BAUD0, 2400, baud rate for baud_rate = 2'b00.
- BAUD1, 4800, baud rate for baud_rate = 2'b01.
- BAUD2, 9600, baud rate for baud_rate = 2'b10.
- BAUD3, 19200, baud rate for baud_rate = 2'b11.
- CNT_W, 16, half-period counter width. Must hold the largest half divisor.

Ports:
- clk  input  1  system clock; all logic on its rising edge.
- rst_n  input  1  synchronous active-low reset.
- baud_rate  input  2  rate select (00=BAUD0, 01=BAUD1, 10=BAUD2, 11=BAUD3).
- baud_clk  output  1  registered baud-rate square wave, 50% duty.

Behaviour:
- Interface: one clock (clk); reset rst_n is synchronous and active-low.
- Half divisors are computed at elaboration, rounded to nearest: HALFn = (CLK_FREQ + BAUDn) / (2*BAUDn), integer division.
- Default half divisors: HALF0 = 10417, HALF1 = 5208, HALF2 = 2604, HALF3 = 1302.
- Elaboration error if any HALFn < 1 or HALFn > 2^CNT_W - 1.
- Reset: on a rising clk edge with rst_n = 0:
  - counter <= 0
  - baud_clk <= 0
  - baud_rate_q <= baud_rate
- Registered select: baud_rate_q holds the previous cycle's baud_rate and updates every cycle. Active divisor HALF_sel is chosen by baud_rate_q.
- Normal operation (rst_n = 1, baud_rate == baud_rate_q):
  - If counter == HALF_sel - 1: counter <= 0 and baud_clk toggles.
  - Otherwise: counter <= counter + 1.
- Output timing: baud_clk period is exactly 2*HALF_sel clk cycles with 50% duty. There is no combinational path from any input to baud_clk.
- Rate change (rst_n = 1, baud_rate != baud_rate_q): counter <= 0, baud_clk <= 0, baud_rate_q <= baud_rate.
- After a rate change the new rate runs from a clean low phase. The first rising edge of baud_clk comes HALF_new cycles after the restart cycle.
- Mid-count: a change of baud_rate always discards the partial count. It never completes the old period.
- Safety: a counter value >= HALF_sel (possible only through a fault) is treated as terminal count — wrap to 0 and toggle. The counter must never run away.
- Reset mid-operation: takes effect on the next clk edge and overrides both counting and rate change.
- First rising edge of baud_clk after reset release comes at HALF_sel cycles.
- X on baud_rate during reset is tolerated. Once rst_n is high, baud_rate must be a known value.
- Accuracy with defaults: error < 0.01% for all four rates.

Test Plan:
- Reset: hold rst_n = 0 for 5 cycles with baud_rate = 00 -> baud_clk = 0 throughout. The first rising edge comes 10417 cycles (208.34 us at 20 ns) after the first cycle with rst_n = 1.
- Rate 00 steady state: measure over 4 periods -> period 20834 cycles (416.68 us), high time 10417 cycles, low time 10417 cycles.
- Rates 01/10/11 in sequence, each held ≥ 4 periods:
  - 01 -> period 10416 cycles (208.32 us)
  - 10 -> period 5208 cycles (104.16 us)
  - 11 -> period 2604 cycles (52.08 us)
  - All at 50% duty.
- Rate change mid-period: switch 00 -> 11 while baud_clk is high at count 5000 -> baud_clk is 0 on the next edge. A rising edge follows 1302 cycles after the restart, then the period is 2604 cycles.
- Reset mid-operation: assert rst_n = 0 for 1 cycle while at rate 10 with baud_clk high -> baud_clk = 0 and counter = 0 on that edge. After release, the first rising edge is at 2604 cycles.
- Re-writing the same baud_rate value every cycle -> no restart; period is unchanged at 2*HALF_sel.
